serial_add_sub: RTL

Parametrised multi-cycle adder/subtractor that replaces the single-bit combinational full-adder stage in the adder/subtractor datapath. It processes WIDTH-bit operands DIGIT bits per clock, LSB digit first, using a DIGIT-bit ripple of full adders and a registered inter-digit carry. It runs under a start/ready/done handshake and reports sum/difference, carry/borrow and signed overflow.

---
 rtl/add_sub_pkg.sv | 22 ++
 rtl/digit_adder.sv | 36 +++
 rtl/full_adder.sv | 15 +
 rtl/serial_add_sub.sv | 124 ++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_t  : controller states (IDLE, CALC)
//   MODE_*   : encodings of the i_sub mode input
//   clog2    : ceiling log2, used to size the digit counter
package add_sub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full_adder cells.
//   a, b  : digit operands
//   cin   : carry into bit 0
//   sum   : digit sum
//   cout  : carry out of the top bit
//   cmsb  : carry into the top bit (the top bit is the word MSB on the
//           last digit, so this feeds the overflow flag)
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[DIGIT];
  assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor. Processes WIDTH-bit operands DIGIT bits
// per clock, LSB digit first, with a registered inter-digit carry.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_start        : request; accepted only while o_ready = 1
//   i_sub          : 0 = a + b, 1 = a - b (sampled on accept)
//   i_a, i_b       : operands (sampled on accept)
//   o_ready        : idle, can accept i_start
//   o_done         : one-cycle pulse when results update
//   o_result       : sum/difference modulo 2^WIDTH
//   o_carry        : final carry (subtract: 1 = no borrow)
//   o_overflow     : two's-complement overflow
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_ready,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_add_sub: WIDTH must be a multiple of DIGIT");
  end

  state_t state, state_nxt;

  // Operands and partial result viewed as N digits so the active digit is
  // selected directly by the counter.
  logic [N-1:0][DIGIT-1:0] op_a, op_b, part, part_nxt;
  logic                    carry_q;
  logic [CW-1:0]           cnt;
  logic                    last;

  logic [DIGIT-1:0]        dsum;
  logic                    dcout, dcmsb;

  assign last    = (cnt == CW'(N - 1));
  assign o_ready = (state == IDLE);

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a   (op_a[cnt]),
    .b   (op_b[cnt]),
    .cin (carry_q),
    .sum (dsum),
    .cout(dcout),
    .cmsb(dcmsb)
  );

  // Partial result with the current digit merged in; on the last digit this
  // is the complete result.
  always_comb begin
    part_nxt      = part;
    part_nxt[cnt] = dsum;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = CALC;
      CALC:    if (last)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      op_a       <= '0;
      op_b       <= '0;
      part       <= '0;
      carry_q    <= 1'b0;
      cnt        <= '0;
      o_done     <= 1'b0;
      o_result   <= '0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            // Subtract as a + ~b + 1: invert b here, inject the +1 as the
            // initial carry.
            op_a    <= i_a;
            op_b    <= (i_sub == MODE_SUB) ? ~i_b : i_b;
            carry_q <= (i_sub == MODE_SUB);
            cnt     <= '0;
            part    <= '0;
          end
        end
        CALC: begin
          part    <= part_nxt;
          carry_q <= dcout;
          cnt     <= last ? '0 : cnt + 1'b1;
          if (last) begin
            o_result   <= part_nxt;
            o_carry    <= dcout;
            o_overflow <= dcmsb ^ dcout;
            o_done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
